// File: rtl/msg_patch_pkg.sv
// rtl/msg_patch_pkg.sv - shared constants and state encoding for the message patch buffer
package msg_patch_pkg;

    localparam int MSG_BYTES = 64;
    localparam int CNT_W     = 49;
    localparam int IDX_W     = 7;
    localparam int OFF_W     = $clog2(MSG_BYTES);

    localparam logic CFG_SEL_MSG  = 1'b0;
    localparam logic CFG_SEL_CSET = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

endpackage

// File: rtl/msg_patch_buffer_charset_lut.sv
// rtl/msg_patch_buffer_charset_lut.sv - 128x8 charset table, host write port and synchronous read port
module charset_lut
    import msg_patch_pkg::*;
(
    input  logic             clk,
    input  logic             we,
    input  logic [IDX_W-1:0] waddr,
    input  logic [7:0]       wdata,
    input  logic [IDX_W-1:0] raddr,
    output logic [7:0]       rdata
);

    // No reset on the array or read register so the tools can map this onto RAM.
    logic [7:0] mem [2**IDX_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/msg_patch_buffer.sv
// rtl/msg_patch_buffer.sv - patches charset-mapped bytes into a 64-byte message block for the hash core
// Build option ENDIAN_SWAP_EN: present msg_block with bytes reversed inside each 32-bit word.
module msg_patch_buffer
    import msg_patch_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cfg_wr,
    input  logic                   cfg_sel,
    input  logic [6:0]             cfg_addr,
    input  logic [7:0]             cfg_data,
    input  logic                   start,
    input  logic [OFF_W-1:0]       upd_offset,
    input  logic [IDX_W-1:0]       upd_idx,
    input  logic [CNT_W-1:0]       upd_counter,
    input  logic                   upd_finished,
    output logic                   msg_valid,
    output logic [8*MSG_BYTES-1:0] msg_block,
    output logic [CNT_W-1:0]       msg_counter,
    output logic                   busy,
    output logic                   done
);

    state_t state, state_nxt;

    logic cfg_ok, base_we, cset_we, start_ok;
    logic [8*MSG_BYTES-1:0] base_q, base_nxt, work_q, work_patched, out_q;
    logic [7:0]       s1_char;
    logic [OFF_W-1:0] s1_off;
    logic [CNT_W-1:0] s1_cnt;
    logic             v1;

    assign cfg_ok   = cfg_wr && (state != ST_RUN);
    assign base_we  = cfg_ok && (cfg_sel == CFG_SEL_MSG) && !cfg_addr[6];
    assign cset_we  = cfg_ok && (cfg_sel == CFG_SEL_CSET);
    assign start_ok = start && (state != ST_RUN);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            ST_IDLE: if (start) state_nxt = ST_RUN;
            ST_RUN: begin
                busy = 1'b1;
                if (upd_finished) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                done = 1'b1;
                if (start) state_nxt = ST_RUN;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // A write coinciding with start is folded in before the copy to the working block.
    always_comb begin
        base_nxt = base_q;
        if (base_we) begin
            base_nxt[{cfg_addr[OFF_W-1:0], 3'b000} +: 8] = cfg_data;
        end
    end

    always_ff @(posedge clk) begin
        base_q <= base_nxt;
    end

    charset_lut u_charset_lut (
        .clk   (clk),
        .we    (cset_we),
        .waddr (cfg_addr[IDX_W-1:0]),
        .wdata (cfg_data),
        .raddr (upd_idx),
        .rdata (s1_char)
    );

    // S1: the charset read happens inside the LUT; offset and counter ride alongside.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v1     <= 1'b0;
            s1_off <= '0;
            s1_cnt <= '0;
        end else begin
            v1     <= (state == ST_RUN) && !upd_finished;
            s1_off <= upd_offset;
            s1_cnt <= upd_counter;
        end
    end

    always_comb begin
        work_patched = work_q;
        if (v1) begin
            work_patched[{s1_off, 3'b000} +: 8] = s1_char;
        end
    end

    // S2: commit the patch and present the already-patched block.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            work_q      <= '0;
            out_q       <= '0;
            msg_counter <= '0;
            msg_valid   <= 1'b0;
        end else begin
            out_q       <= work_patched;
            msg_counter <= s1_cnt;
            if (start_ok) begin
                work_q    <= base_nxt;
                msg_valid <= 1'b0;
            end else begin
                work_q    <= work_patched;
                msg_valid <= v1;
            end
        end
    end

    for (genvar k = 0; k < MSG_BYTES; k++) begin : g_out
`ifdef ENDIAN_SWAP_EN
        assign msg_block[8*k +: 8] = out_q[8*(k ^ 3) +: 8];
`else
        assign msg_block[8*k +: 8] = out_q[8*k +: 8];
`endif
    end

endmodule

// File: tb/tb_msg_patch_buffer.sv
// tb/tb_msg_patch_buffer.sv - scoreboard bench for msg_patch_buffer (honours ENDIAN_SWAP_EN)
module tb_msg_patch_buffer;
    import msg_patch_pkg::*;

    logic                   clk = 1'b0;
    logic                   reset = 1'b0;
    logic                   cfg_wr = 1'b0;
    logic                   cfg_sel = 1'b0;
    logic [6:0]             cfg_addr = '0;
    logic [7:0]             cfg_data = '0;
    logic                   start = 1'b0;
    logic [OFF_W-1:0]       upd_offset = '0;
    logic [IDX_W-1:0]       upd_idx = '0;
    logic [CNT_W-1:0]       upd_counter = '0;
    logic                   upd_finished = 1'b0;
    logic                   msg_valid;
    logic [8*MSG_BYTES-1:0] msg_block;
    logic [CNT_W-1:0]       msg_counter;
    logic                   busy;
    logic                   done;

    always #5 clk = ~clk;

    msg_patch_buffer dut (
        .clk          (clk),
        .reset        (reset),
        .cfg_wr       (cfg_wr),
        .cfg_sel      (cfg_sel),
        .cfg_addr     (cfg_addr),
        .cfg_data     (cfg_data),
        .start        (start),
        .upd_offset   (upd_offset),
        .upd_idx      (upd_idx),
        .upd_counter  (upd_counter),
        .upd_finished (upd_finished),
        .msg_valid    (msg_valid),
        .msg_block    (msg_block),
        .msg_counter  (msg_counter),
        .busy         (busy),
        .done         (done)
    );

    logic [7:0] m_base [MSG_BYTES];
    logic [7:0] m_cset [128];
    logic [7:0] m_work [MSG_BYTES];
    logic [8*MSG_BYTES-1:0] q_blk [$];
    logic [CNT_W-1:0]       q_cnt [$];
    int total = 0;
    int bad   = 0;

    function automatic logic [8*MSG_BYTES-1:0] pack_work();
        logic [8*MSG_BYTES-1:0] b;
        b = '0;
        for (int k = 0; k < MSG_BYTES; k++) begin
`ifdef ENDIAN_SWAP_EN
            b[8*((k & ~3) | (3 - (k & 3))) +: 8] = m_work[k];
`else
            b[8*k +: 8] = m_work[k];
`endif
        end
        return b;
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cfg_wr       = 1'b0;
        start        = 1'b0;
        upd_finished = 1'b0;
    endtask

    task automatic cfg(input logic sel, input logic [6:0] addr, input logic [7:0] data);
        cfg_wr   = 1'b1;
        cfg_sel  = sel;
        cfg_addr = addr;
        cfg_data = data;
        tick();
    endtask

    task automatic upd(input int off, input int idx, input logic [CNT_W-1:0] cnt);
        upd_offset  = OFF_W'(off);
        upd_idx     = IDX_W'(idx);
        upd_counter = cnt;
        m_work[off] = m_cset[idx];
        q_blk.push_back(pack_work());
        q_cnt.push_back(cnt);
        tick();
    endtask

    task automatic load_work();
        for (int k = 0; k < MSG_BYTES; k++) m_work[k] = m_base[k];
    endtask

    always @(negedge clk) begin
        if (msg_valid === 1'b1) begin
            total++;
            if (q_blk.size() == 0) begin
                bad++;
                $display("FAIL unexpected_valid got=1 exp=0 counter=%0d", msg_counter);
            end else begin
                logic [8*MSG_BYTES-1:0] eb;
                logic [CNT_W-1:0]       ec;
                eb = q_blk.pop_front();
                ec = q_cnt.pop_front();
                if (msg_block !== eb || msg_counter !== ec) begin
                    bad++;
                    $display("FAIL out_block cnt got=%0d exp=%0d blk got=%h exp=%h",
                             msg_counter, ec, msg_block, eb);
                end
            end
        end
    end

    initial begin
        #2 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 64'(msg_valid), 64'd0);
        check("rst_block_or", 64'(|msg_block), 64'd0);
        check("rst_counter", 64'(msg_counter), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        reset = 1'b0;
        tick();

        for (int i = 0; i < MSG_BYTES; i++) begin
            cfg(CFG_SEL_MSG, 7'(i), 8'h00);
            m_base[i] = 8'h00;
        end
        for (int i = 0; i < 128; i++) begin
            cfg(CFG_SEL_CSET, 7'(i), 8'(8'h61 + i));
            m_cset[i] = 8'(8'h61 + i);
        end
        // offset field out of range: must not alias onto byte 10
        cfg(CFG_SEL_MSG, 7'h4A, 8'hEE);

        // test 1 and 2
        start = 1'b1;
        tick();
        load_work();
        check("run_busy", 64'(busy), 64'd1);
        upd(3, 2, 49'd10);
        upd(5, 0, 49'd11);
        upd(5, 1, 49'd12);

        // test 3: charset write during RUN is ignored
        cfg_wr = 1'b1; cfg_sel = CFG_SEL_CSET; cfg_addr = 7'd2; cfg_data = 8'hFF;
        upd(20, 6, 49'd13);
        upd_finished = 1'b1;
        upd_offset = 6'd40; upd_idx = 7'd9; upd_counter = 49'd99;
        tick();
        check("fin_done", 64'(done), 64'd1);
        check("fin_busy", 64'(busy), 64'd0);
        repeat (3) tick();
        check("fin_drained", 64'(q_blk.size()), 64'd0);

        // test 4: base write + start + finished together in DONE
        cfg_wr = 1'b1; cfg_sel = CFG_SEL_MSG; cfg_addr = 7'd0; cfg_data = 8'h41;
        start = 1'b1; upd_finished = 1'b1;
        tick();
        m_base[0] = 8'h41;
        load_work();
        check("restart_busy", 64'(busy), 64'd1);
        check("restart_done", 64'(done), 64'd0);
        upd(7, 3, 49'd20);
        upd(0, 4, 49'd21);
        upd_finished = 1'b1;
        tick();
        tick();
`ifdef ENDIAN_SWAP_EN
        check("byte0_lane", 64'(msg_block[31:24]), 64'h65);
`else
        check("byte0_lane", 64'(msg_block[7:0]), 64'h65);
`endif
        repeat (2) tick();

        // test 5: reset mid-RUN
        start = 1'b1;
        tick();
        load_work();
        upd(1, 5, 49'd30);
        upd(2, 6, 49'd31);
        reset = 1'b1;
        q_blk.delete();
        q_cnt.delete();
        #1;
        check("midrst_valid", 64'(msg_valid), 64'd0);
        check("midrst_block_or", 64'(|msg_block), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_done", 64'(done), 64'd0);
        repeat (2) tick();
        check("midrst_hold_valid", 64'(msg_valid), 64'd0);
        reset = 1'b0;
        tick();
        start = 1'b1;
        tick();
        load_work();
        upd(9, 2, 49'd40);
        upd_finished = 1'b1;
        tick();
        repeat (3) tick();
        check("end_drained", 64'(q_blk.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
